// File: rtl/systolic_seq_if.sv
// Purpose: bundles the sequencer's control, operand-buffer and array-edge
//   signals. Signal prefixes are from the sequencer's point of view.
// Ports (slave = sequencer side):
//   i_start, i_k_len         matmul request and inner dimension
//   o_busy, o_done           status; o_done is a one-cycle pulse
//   o_rd_en, o_rd_addr       operand buffer read strobe and k address
//   i_a_rdata, i_b_rdata     A column / B row, valid 1 cycle after o_rd_en
//   o_pe_clear               accumulator clear to the PE array
//   o_west_data, o_north_data skewed edge data into the array
interface systolic_seq_if #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int K_MAX = 16
) ();
  localparam int KW = $clog2(K_MAX + 1);
  localparam int AW = $clog2(K_MAX);

  logic              i_start;
  logic [KW-1:0]     i_k_len;
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [AW-1:0]     o_rd_addr;
  logic [N*DW-1:0]   i_a_rdata;
  logic [N*DW-1:0]   i_b_rdata;
  logic              o_pe_clear;
  logic [N*DW-1:0]   o_west_data;
  logic [N*DW-1:0]   o_north_data;

  modport slave (
    input  i_start, i_k_len, i_a_rdata, i_b_rdata,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_pe_clear,
           o_west_data, o_north_data
  );

  modport master (
    output i_start, i_k_len, i_a_rdata, i_b_rdata,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_pe_clear,
           o_west_data, o_north_data
  );
endinterface

// File: rtl/systolic_seq.sv
// Purpose: sequencer for an NxN systolic PE array. Clears the PE accumulators,
//   streams k_len A-column / B-row vectors from the operand buffers onto the
//   west/north edges with a per-lane skew, waits 2N cycles for the array to
//   drain, then pulses done.
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    systolic_seq_if.slave (control, operand buffer, array edges)
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start; k_len latched (clamped) on start
// S_CLEAR | one cycle of pe_clear
// S_FEED  | kl cycles of operand reads, rd_addr = k
// S_DRAIN | 2N cycles while the last operands ripple through the array
// S_DONE  | one-cycle done pulse; start ignored here
module systolic_seq #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int K_MAX = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  systolic_seq_if.slave bus
);
  localparam int KW  = $clog2(K_MAX + 1);
  localparam int AW  = $clog2(K_MAX);
  localparam int DCW = $clog2(2 * N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_kl;
  logic [AW-1:0]   r_k;
  logic [DCW-1:0]  r_drain;
  logic            r_vld;

  logic [KW-1:0]   w_kl_clamp;
  logic            w_k_last;
  logic            w_drain_last;
  logic            w_busy, w_done, w_rd_en, w_pe_clear;
  logic [N*DW-1:0] w_a_edge, w_b_edge;

  assign w_kl_clamp   = (bus.i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.i_k_len;
  assign w_k_last     = (KW'(r_k) == (r_kl - KW'(1)));
  assign w_drain_last = (r_drain == DCW'(2 * N - 1));

  // Counters hold at their last value instead of incrementing past it, so a
  // full K_MAX-long feed never wraps the AW-bit k counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_kl    <= '0;
      r_k     <= '0;
      r_drain <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= w_rd_en;
      if (r_state == S_IDLE && bus.i_start) r_kl <= w_kl_clamp;
      if (r_state != S_FEED)   r_k <= '0;
      else if (!w_k_last)      r_k <= r_k + AW'(1);
      if (r_state != S_DRAIN)  r_drain <= '0;
      else if (!w_drain_last)  r_drain <= r_drain + DCW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_rd_en     = 1'b0;
    w_pe_clear  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_busy      = 1'b1;
        w_pe_clear  = 1'b1;
        w_state_nxt = (r_kl == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        w_busy  = 1'b1;
        w_rd_en = 1'b1;
        if (w_k_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_drain_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.o_busy     = w_busy;
  assign bus.o_done     = w_done;
  assign bus.o_rd_en    = w_rd_en;
  assign bus.o_pe_clear = w_pe_clear;
  assign bus.o_rd_addr  = r_k;

  // Edge values are forced to zero outside valid read data so that skew
  // padding contributes nothing to the PE accumulators.
  assign w_a_edge = r_vld ? bus.i_a_rdata : '0;
  assign w_b_edge = r_vld ? bus.i_b_rdata : '0;

  // Lane i lands on the array edge i cycles after its read data returns. The
  // last skew stage of each lane is the edge register; lane 0 needs no delay
  // and is driven straight from the gated read data (r_vld is registered).
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    if (gi == 0) begin : g_pass
      assign bus.o_west_data[DW-1:0]  = w_a_edge[DW-1:0];
      assign bus.o_north_data[DW-1:0] = w_b_edge[DW-1:0];
    end else begin : g_skew
      logic [DW-1:0] r_w [gi];
      logic [DW-1:0] r_n [gi];
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int s = 0; s < gi; s++) begin
            r_w[s] <= '0;
            r_n[s] <= '0;
          end
        end else begin
          r_w[0] <= w_a_edge[gi*DW +: DW];
          r_n[0] <= w_b_edge[gi*DW +: DW];
          for (int s = 1; s < gi; s++) begin
            r_w[s] <= r_w[s-1];
            r_n[s] <= r_n[s-1];
          end
        end
      end
      assign bus.o_west_data[gi*DW +: DW]  = r_w[gi-1];
      assign bus.o_north_data[gi*DW +: DW] = r_n[gi-1];
    end
  end
endmodule

// File: tb/tb_systolic_seq.sv
module tb_systolic_seq;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int K_MAX = 16;
  localparam int KW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_seq_if #(.N(N), .DW(DW), .K_MAX(K_MAX)) bus ();
  systolic_seq #(.N(N), .DW(DW), .K_MAX(K_MAX)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Operand buffers: amem[k][i] = A[i][k], bmem[k][j] = B[k][j].
  logic [DW-1:0] amem [K_MAX][N];
  logic [DW-1:0] bmem [K_MAX][N];

  // Behavioural PE array fed by the DUT edges.
  int unsigned   acc [N][N];
  logic [DW-1:0] pw  [N][N];
  logic [DW-1:0] pn  [N][N];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Operand buffer: one-cycle read latency, garbage when not read.
  logic       pend_vld;
  logic [3:0] pend_addr;
  always begin
    @(negedge clk);
    pend_vld  = bus.o_rd_en;
    pend_addr = bus.o_rd_addr;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      bus.i_a_rdata[i*DW +: DW] = pend_vld ? amem[pend_addr][i] : DW'($urandom);
      bus.i_b_rdata[i*DW +: DW] = pend_vld ? bmem[pend_addr][i] : DW'($urandom);
    end
  end

  function automatic logic [31:0] exp_edge(input bit is_b, input int d, input int kl);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = d - 3 - i;
      if (k >= 0 && k < kl) v[i*DW +: DW] = is_b ? bmem[k][i] : amem[k][i];
    end
    return v;
  endfunction

  task automatic check_quiet(input string tag);
    check_val({tag, "_busy"},  32'(bus.o_busy), 0);
    check_val({tag, "_done"},  32'(bus.o_done), 0);
    check_val({tag, "_rden"},  32'(bus.o_rd_en), 0);
    check_val({tag, "_clr"},   32'(bus.o_pe_clear), 0);
    check_val({tag, "_addr"},  32'(bus.o_rd_addr), 0);
    check_val({tag, "_west"},  bus.o_west_data, 0);
    check_val({tag, "_north"}, bus.o_north_data, 0);
  endtask

  task automatic pe_step();
    logic [DW-1:0] nw [N][N];
    logic [DW-1:0] nn [N][N];
    if (bus.o_pe_clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0; pw[i][j] = '0; pn[i][j] = '0;
        end
      return;
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        nw[i][j] = (j == 0) ? bus.o_west_data[i*DW +: DW]  : pw[i][j-1];
        nn[i][j] = (i == 0) ? bus.o_north_data[j*DW +: DW] : pn[i-1][j];
        acc[i][j] += 32'(nw[i][j]) * 32'(nn[i][j]);
      end
    pw = nw;
    pn = nn;
  endtask

  task automatic check_pe(input int kl);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int unsigned s;
        s = 0;
        for (int k = 0; k < kl; k++) s += 32'(amem[k][i]) * 32'(bmem[k][j]);
        check_val($sformatf("pe%0d%0d", i, j), acc[i][j], s);
      end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        amem[k][i] = DW'($urandom);
        bmem[k][i] = DW'($urandom);
      end
  endtask

  // Called just after a rising edge; start is held for that one cycle (t0).
  task automatic run_op(input int kreq, input int abort_d, input bit poke);
    int kl, done_d;
    kl     = (kreq > K_MAX) ? K_MAX : kreq;
    done_d = (kl == 0) ? 2 : 2 + kl + 2 * N;
    bus.i_start = 1'b1;
    bus.i_k_len = KW'(kreq);
    for (int d = 1; d <= done_d + 1; d++) begin
      @(posedge clk);
      #1;
      bus.i_start = poke && (d == 3 || d == done_d);
      bus.i_k_len = KW'($urandom);
      if (d == abort_d) begin
        check_val("abort_addr", 32'(bus.o_rd_addr), d - 2);
        #2 rst = 1'b1;
        #1 check_quiet("rst_async");
        bus.i_start = 1'b0;
        @(negedge clk);
        check_quiet("rst_hold");
        rst = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      check_val($sformatf("busy d%0d", d),  32'(bus.o_busy),     32'(d >= 1 && d < done_d));
      check_val($sformatf("done d%0d", d),  32'(bus.o_done),     32'(d == done_d));
      check_val($sformatf("clr d%0d", d),   32'(bus.o_pe_clear), 32'(d == 1));
      check_val($sformatf("rden d%0d", d),  32'(bus.o_rd_en),    32'(d >= 2 && d <= 1 + kl));
      if (d >= 2 && d <= 1 + kl)
        check_val($sformatf("addr d%0d", d), 32'(bus.o_rd_addr), d - 2);
      check_val($sformatf("west d%0d", d),  bus.o_west_data,  exp_edge(1'b0, d, kl));
      check_val($sformatf("north d%0d", d), bus.o_north_data, exp_edge(1'b1, d, kl));
      if (d == done_d) check_pe(kl);
      pe_step();
    end
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_k_len = '0;
    fill_rand();
    #3 check_quiet("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_idle");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Skew pattern, kl=1
    for (int i = 0; i < N; i++) begin
      amem[0][i] = DW'(i + 1);
      bmem[0][i] = DW'(5 + i);
    end
    run_op(1, 0, 1'b0);

    // Identity times 1..16
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        amem[k][i] = DW'(i == k);
        bmem[k][i] = DW'(4 * k + i + 1);
      end
    run_op(4, 0, 1'b0);

    // Starts while busy and in DONE are ignored
    fill_rand();
    run_op(6, 0, 1'b1);

    // kl=0 and clamp of an oversized k_len
    run_op(0, 0, 1'b0);
    fill_rand();
    run_op(31, 0, 1'b0);

    // Reset during FEED at k=2, then a clean kl=2 run
    fill_rand();
    run_op(8, 4, 1'b0);
    check_quiet("after_abort");
    run_op(2, 0, 1'b0);

    repeat (5) begin
      fill_rand();
      run_op($urandom_range(1, K_MAX), 0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
